// File: rtl/alu_pkg.sv
// Shared opcode encoding and widths for the small ALU.
package alu_pkg;

  localparam int unsigned OP_W = 2;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_ADD = 2'b00;
  localparam op_t OP_SUB = 2'b01;
  localparam op_t OP_AND = 2'b10;
  localparam op_t OP_OR  = 2'b11;

endpackage : alu_pkg

// File: rtl/alu_core.sv
// Combinational ALU datapath: add, subtract, bitwise AND and OR of two unsigned operands.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  op_t              op,
  output logic [WIDTH-1:0] res
);

  localparam int unsigned EXT_W = WIDTH + 1;

  logic [EXT_W-1:0] a_ext;
  logic [EXT_W-1:0] b_ext;
  logic [EXT_W-1:0] sum_ext;
  logic [EXT_W-1:0] diff_ext;

  // Carry/borrow live in the extra bit and are dropped on truncation.
  always_comb begin
    a_ext    = {1'b0, inA};
    b_ext    = {1'b0, inB};
    sum_ext  = a_ext + b_ext;
    diff_ext = a_ext - b_ext;
  end

  always_comb begin
    res = '0;
    case (op)
      OP_ADD:  res = WIDTH'(sum_ext);
      OP_SUB:  res = WIDTH'(diff_ext);
      OP_AND:  res = inA & inB;
      OP_OR:   res = inA | inB;
      default: res = '0;
    endcase
  end

endmodule : alu_core

// File: rtl/alu4_reg.sv
// Registered ALU: result and zero flag captured one clock after operand/op sampling.
module alu4_reg
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] ans,
  output logic             zero
);

  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] ans_d;
  logic [WIDTH-1:0] ans_q;
  logic             zero_d;
  logic             zero_q;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .inA (inA),
    .inB (inB),
    .op  (op_t'(op)),
    .res (res)
  );

  always_comb begin
    ans_d  = res;
    zero_d = (res == '0);
  end

  // Reset wins over any operation and discards that cycle's result.
  always_ff @(posedge clk) begin
    if (reset) begin
      ans_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      ans_q  <= ans_d;
      zero_q <= zero_d;
    end
  end

  assign ans  = ans_q;
  assign zero = zero_q;

endmodule : alu4_reg

// File: tb/tb_alu4_reg.sv
// Self-checking bench for alu4_reg at WIDTH=4: directed table, corner sequences, random model.
module tb_alu4_reg;

  logic       clk;
  logic       reset;
  logic [3:0] inA;
  logic [3:0] inB;
  logic [1:0] op;
  logic [3:0] ans;
  logic       zero;

  int n_cmp;
  int n_err;

  alu4_reg #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .inA   (inA),
    .inB   (inB),
    .op    (op),
    .ans   (ans),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] o;
    logic [3:0] exp_ans;
    logic       exp_zero;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive on the falling edge, then sample 1 time unit after the rising edge.
  task automatic apply(input logic rst, input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] o);
    @(negedge clk);
    reset = rst;
    inA   = a;
    inB   = b;
    op    = o;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic [1:0] o);
    int r;
    case (o)
      2'd0:    r = (int'(a) + int'(b)) % 16;
      2'd1:    r = (int'(a) - int'(b) + 16) % 16;
      2'd2:    r = int'(a & b);
      default: r = int'(a | b);
    endcase
    return 4'(r);
  endfunction

  initial begin
    logic [3:0] ra;
    logic [3:0] rb;
    logic [1:0] ro;
    logic [3:0] held;

    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    inA   = '0;
    inB   = '0;
    op    = '0;

    vecs.push_back('{"rst_hold0",  1'b1, 4'd7,  4'd3, 2'b00, 4'd0,  1'b1});
    vecs.push_back('{"rst_hold1",  1'b1, 4'd7,  4'd3, 2'b00, 4'd0,  1'b1});
    vecs.push_back('{"rst_release",1'b0, 4'd7,  4'd3, 2'b00, 4'd10, 1'b0});
    vecs.push_back('{"add_1_1",    1'b0, 4'd1,  4'd1, 2'b00, 4'd2,  1'b0});
    vecs.push_back('{"sub_1_1",    1'b0, 4'd1,  4'd1, 2'b01, 4'd0,  1'b1});
    vecs.push_back('{"and_1_1",    1'b0, 4'd1,  4'd1, 2'b10, 4'd1,  1'b0});
    vecs.push_back('{"or_1_1",     1'b0, 4'd1,  4'd1, 2'b11, 4'd1,  1'b0});
    vecs.push_back('{"add_wrap",   1'b0, 4'd15, 4'd1, 2'b00, 4'd0,  1'b1});
    vecs.push_back('{"sub_wrap",   1'b0, 4'd0,  4'd1, 2'b01, 4'd15, 1'b0});
    vecs.push_back('{"and_pat",    1'b0, 4'hA,  4'h6, 2'b10, 4'h2,  1'b0});
    vecs.push_back('{"or_pat",     1'b0, 4'hA,  4'h6, 2'b11, 4'hE,  1'b0});
    vecs.push_back('{"add_ff",     1'b0, 4'd15, 4'd15,2'b00, 4'd14, 1'b0});
    vecs.push_back('{"sub_3_5",    1'b0, 4'd3,  4'd5, 2'b01, 4'd14, 1'b0});
    vecs.push_back('{"and_zero",   1'b0, 4'h5,  4'hA, 2'b10, 4'd0,  1'b1});
    vecs.push_back('{"or_zero",    1'b0, 4'd0,  4'd0, 2'b11, 4'd0,  1'b1});
    vecs.push_back('{"mid_pre",    1'b0, 4'd5,  4'd5, 2'b00, 4'd10, 1'b0});
    vecs.push_back('{"mid_rst",    1'b1, 4'd5,  4'd5, 2'b00, 4'd0,  1'b1});
    vecs.push_back('{"mid_post",   1'b0, 4'd5,  4'd5, 2'b00, 4'd10, 1'b0});
    vecs.push_back('{"rst_over_or",1'b1, 4'hF,  4'hF, 2'b11, 4'd0,  1'b1});
    vecs.push_back('{"post_or",    1'b0, 4'hF,  4'h0, 2'b11, 4'hF,  1'b0});

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].o);
      check({vecs[i].name, ".ans"},  ans,         vecs[i].exp_ans);
      check({vecs[i].name, ".zero"}, {3'b0, zero}, {3'b0, vecs[i].exp_zero});
    end

    // Inputs changed between edges must not reach ans before the next edge.
    apply(1'b0, 4'd2, 4'd3, 2'b00);
    held = ans;
    check("settle.ans", held, 4'd5);
    inA = 4'd9;
    inB = 4'd9;
    op  = 2'b11;
    #2;
    check("no_glitch.ans", ans, 4'd5);
    check("no_glitch.zero", {3'b0, zero}, 4'd0);
    inA = 4'd0;
    inB = 4'd0;
    op  = 2'b00;
    @(posedge clk);
    #1;
    check("late_change.ans", ans, 4'd0);
    check("late_change.zero", {3'b0, zero}, 4'd1);

    // Random stream against the reference model with one-cycle latency.
    for (int i = 0; i < 1000; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      ro = 2'($urandom_range(0, 3));
      apply(1'b0, ra, rb, ro);
      check("rand.ans", ans, model(ra, rb, ro));
      check("rand.zero", {3'b0, zero}, {3'b0, (model(ra, rb, ro) == 4'd0)});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_alu4_reg
